out_buffer: RTL and testbench
=============================

OUT_BUFFER -- requirements
Module: out_buffer

Interface
REQ-001 Parameter WIDTH, 16, data word width in bits.
REQ-002 Parameter DEPTH, 4, number of buffered words; power of two, at least 2.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst_b  input  1  reset; synchronous and active-low.
REQ-005 en  input  1  write strobe from the internal bus; a word is presented on in.
REQ-006 in  input  WIDTH  word to buffer; sampled only on a cycle where a write is accepted.
REQ-007 clr_ovf  input  1  clears the sticky overflow flag.
REQ-008 out_ready  input  1  consumer accepts the head word this cycle.
REQ-009 out_valid  output  1  head word present on out.
REQ-010 out  output  WIDTH  head word (first-word-fall-through).
REQ-011 full  output  1  count equals DEPTH.
REQ-012 count  output  log2(DEPTH)+1  number of stored words, 0..DEPTH.
REQ-013 overflow  output  1  sticky flag; a write was dropped.

Function
REQ-014 Storage SHALL be a DEPTH-entry circular buffer with read and write pointers of log2(DEPTH) bits that wrap from DEPTH-1 to 0.
REQ-015 Occupancy states SHALL be EMPTY (count=0), PARTIAL (0<count<DEPTH) and FULL (count=DEPTH); transitions occur only through accepted push/pop.
REQ-016 Push SHALL be accepted when en=1 and full=0; the word is written at the write pointer, which then advances.
REQ-017 Pop SHALL occur when out_valid=1 and out_ready=1; the read pointer advances.
REQ-018 Push and pop in the same cycle SHALL leave count unchanged; in PARTIAL both pointers advance.
REQ-019 In EMPTY, en=1 with out_ready=1 SHALL perform the push only; out_valid rises the following cycle (latency 1, no bypass).
REQ-020 In FULL, en=1 with a simultaneous pop SHALL drop the write (full is evaluated before the pop) and set overflow.
REQ-021 en=1 while full=1 SHALL leave storage, pointers and count unchanged and set overflow to 1 on the next edge.
REQ-022 overflow SHALL clear on clr_ovf=1 unless a dropped write occurs in the same cycle; set has priority.
REQ-023 out_valid SHALL equal (count != 0); full SHALL equal (count == DEPTH); both are registered-state derived, not combinational from inputs.
REQ-024 out SHALL show the word at the read pointer while out_valid=1, held stable until popped, and SHALL read 0 while out_valid=0.
REQ-025 out_ready while out_valid=0 SHALL have no effect.
REQ-026 Words SHALL leave in exactly the order they were accepted; no word is duplicated or lost except dropped writes.

Reset
REQ-027 On a rising edge with rst_b=0, pointers, count and overflow SHALL become 0; out_valid=0, full=0, out=0 on the following cycle.
REQ-028 Reset SHALL take priority over en, out_ready and clr_ovf in the same cycle; buffered words are discarded (storage content need not be cleared).
REQ-029 No state SHALL change asynchronously on rst_b; reset asserted mid-transfer takes effect at the next edge only.

Verification
REQ-030 Reset, then en=1 in=16'h1234 for one cycle -> next cycle out_valid=1, out=16'h1234, count=1; out_ready=1 -> following cycle out_valid=0, out=0, count=0.
REQ-031 Push 16'h0001..16'h0004 on consecutive cycles with out_ready=0 -> full=1, count=4; en=1 in=16'h0005 -> overflow=1, count=4; drain returns 0001,0002,0003,0004 in order.
REQ-032 FULL with en=1 in=16'hBEEF and out_ready=1 same cycle -> count=3, overflow=1, 16'hBEEF never appears on out.
REQ-033 count=2, en=1 and out_ready=1 held for 10 cycles with incrementing data -> count stays 2, pointers wrap at least twice, output order matches input order.
REQ-034 overflow=1, clr_ovf=1 with en=0 -> overflow=0; clr_ovf=1 with en=1 while full -> overflow stays 1.
REQ-035 count=3, rst_b=0 for one edge with en=1 and out_ready=1 -> count=0, out_valid=0, overflow=0; rst_b asserted between edges changes nothing until the edge.

Source files
------------

// File: rtl/out_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : out_buffer
//  Description : First-word-fall-through output buffer between an internal
//                write bus and a ready/valid consumer. Writes arriving while
//                the buffer is full are dropped and recorded in a sticky
//                overflow flag.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk        : clock, all state changes on the rising edge
//    rst_b      : synchronous active-low reset
//    en         : write strobe; word presented on 'in'
//    in         : write data, sampled only when the write is accepted
//    clr_ovf    : clears the sticky overflow flag (a same-cycle drop wins)
//    out_ready  : consumer accepts the head word this cycle
//    out_valid  : head word present on 'out'
//    out        : head word, reads 0 while the buffer is empty
//    full       : buffer holds DEPTH words
//    count      : number of stored words, 0..DEPTH
//    overflow   : sticky, set when a write was dropped
// ============================================================================
module out_buffer #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_b,
    input  logic                     en,
    input  logic [WIDTH-1:0]         in,
    input  logic                     clr_ovf,
    input  logic                     out_ready,
    output logic                     out_valid,
    output logic [WIDTH-1:0]         out,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] c_full_count = CW'(DEPTH);

    typedef enum logic [1:0] {
        S_EMPTY   = 2'd0,
        S_PARTIAL = 2'd1,
        S_FULL    = 2'd2
    } occ_state_t;

    occ_state_t         r_state;
    occ_state_t         w_state_nxt;
    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [AW-1:0]      r_wr_ptr;
    logic [AW-1:0]      r_rd_ptr;
    logic [CW-1:0]      r_count;
    logic [CW-1:0]      w_count_nxt;
    logic               r_overflow;
    logic               w_push;
    logic               w_pop;
    logic               w_drop;

    // Push/pop qualification and occupancy next-state. Fullness is judged on
    // the registered state, so a write in FULL is dropped even when the
    // consumer pops in the same cycle.
    always_comb begin
        w_state_nxt = r_state;
        w_push      = en && (r_state != S_FULL);
        w_pop       = out_ready && (r_state != S_EMPTY);
        w_drop      = en && (r_state == S_FULL);
        w_count_nxt = r_count;

        if (w_push && !w_pop) begin
            w_count_nxt = r_count + CW'(1);
        end else if (w_pop && !w_push) begin
            w_count_nxt = r_count - CW'(1);
        end

        case (r_state)
            S_EMPTY: begin
                // No bypass: a push into an empty buffer is visible next cycle.
                if (w_push) begin
                    w_state_nxt = (w_count_nxt == c_full_count) ? S_FULL : S_PARTIAL;
                end
            end
            S_PARTIAL: begin
                if (w_count_nxt == '0) begin
                    w_state_nxt = S_EMPTY;
                end else if (w_count_nxt == c_full_count) begin
                    w_state_nxt = S_FULL;
                end
            end
            S_FULL: begin
                if (w_pop) begin
                    w_state_nxt = (w_count_nxt == '0) ? S_EMPTY : S_PARTIAL;
                end
            end
            default: begin
                w_state_nxt = S_EMPTY;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_b) begin
            r_state    <= S_EMPTY;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_count <= w_count_nxt;
            // Power-of-two depth: pointers wrap DEPTH-1 -> 0 by overflow.
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            // A dropped write outranks a clear in the same cycle.
            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (clr_ovf) begin
                r_overflow <= 1'b0;
            end
        end
    end

    // Storage is not reset; stale entries are unreachable once the pointers
    // and count are cleared.
    always_ff @(posedge clk) begin
        if (rst_b && w_push) begin
            r_mem[r_wr_ptr] <= in;
        end
    end

    assign out_valid = (r_state != S_EMPTY);
    assign full      = (r_state == S_FULL);
    assign count     = r_count;
    assign overflow  = r_overflow;
    assign out       = out_valid ? r_mem[r_rd_ptr] : '0;

endmodule
`default_nettype wire

// File: tb/tb_out_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_out_buffer
//  Description : Directed self-checking bench for out_buffer (WIDTH=16,
//                DEPTH=4). Status is compared as the packed vector
//                {out_valid, full, count[2:0], overflow, out[15:0]}.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_out_buffer;

    logic        clk;
    logic        rst_b;
    logic        en;
    logic [15:0] in;
    logic        clr_ovf;
    logic        out_ready;
    logic        out_valid;
    logic [15:0] out;
    logic        full;
    logic [2:0]  count;
    logic        overflow;

    int n_tests = 0;
    int n_fail  = 0;

    out_buffer #(
        .WIDTH (16),
        .DEPTH (4)
    ) dut (
        .clk       (clk),
        .rst_b     (rst_b),
        .en        (en),
        .in        (in),
        .clr_ovf   (clr_ovf),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out       (out),
        .full      (full),
        .count     (count),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge; inputs change and outputs are sampled 1 time unit
    // after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [21:0] st(input logic v, input logic f,
                                       input logic [2:0] c, input logic o,
                                       input logic [15:0] d);
        return {v, f, c, o, d};
    endfunction

    task automatic test_reset();
        rst_b = 1'b0; en = 1'b0; in = '0; clr_ovf = 1'b0; out_ready = 1'b0;
        tick(); tick();
        rst_b = 1'b1;
        n_tests++;
        if (st(out_valid, full, count, overflow, out) !== st(0, 0, 3'd0, 0, 16'h0)) begin
            n_fail++;
            $display("FAIL reset_state: got %h expected %h", st(out_valid, full, count, overflow, out), st(0, 0, 3'd0, 0, 16'h0));
        end
        // out_ready on an empty buffer must do nothing
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        n_tests++;
        if (st(out_valid, full, count, overflow, out) !== st(0, 0, 3'd0, 0, 16'h0)) begin
            n_fail++;
            $display("FAIL ready_when_empty: got %h expected %h", st(out_valid, full, count, overflow, out), st(0, 0, 3'd0, 0, 16'h0));
        end
    endtask

    task automatic test_single();
        en = 1'b1; in = 16'h1234; out_ready = 1'b1;   // push only, no bypass
        n_tests++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL no_bypass: got out_valid=%b expected 0", out_valid);
        end
        tick();
        en = 1'b0; out_ready = 1'b0;
        n_tests++;
        if (st(out_valid, full, count, overflow, out) !== st(1, 0, 3'd1, 0, 16'h1234)) begin
            n_fail++;
            $display("FAIL single_push: got %h expected %h", st(out_valid, full, count, overflow, out), st(1, 0, 3'd1, 0, 16'h1234));
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        n_tests++;
        if (st(out_valid, full, count, overflow, out) !== st(0, 0, 3'd0, 0, 16'h0)) begin
            n_fail++;
            $display("FAIL single_pop: got %h expected %h", st(out_valid, full, count, overflow, out), st(0, 0, 3'd0, 0, 16'h0));
        end
    endtask

    task automatic test_fill_overflow();
        for (int i = 1; i <= 4; i++) begin
            en = 1'b1; in = 16'(i);
            tick();
        end
        en = 1'b0;
        n_tests++;
        if (st(out_valid, full, count, overflow, out) !== st(1, 1, 3'd4, 0, 16'h0001)) begin
            n_fail++;
            $display("FAIL fill_full: got %h expected %h", st(out_valid, full, count, overflow, out), st(1, 1, 3'd4, 0, 16'h0001));
        end
        en = 1'b1; in = 16'h0005;
        tick();
        en = 1'b0;
        n_tests++;
        if (st(out_valid, full, count, overflow, out) !== st(1, 1, 3'd4, 1, 16'h0001)) begin
            n_fail++;
            $display("FAIL overflow_set: got %h expected %h", st(out_valid, full, count, overflow, out), st(1, 1, 3'd4, 1, 16'h0001));
        end
        out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            n_tests++;
            if (out_valid !== 1'b1 || out !== 16'(i)) begin
                n_fail++;
                $display("FAIL drain_order[%0d]: got valid=%b out=%h expected valid=1 out=%h", i, out_valid, out, 16'(i));
            end
            tick();
        end
        out_ready = 1'b0;
        n_tests++;
        if (st(out_valid, full, count, overflow, out) !== st(0, 0, 3'd0, 1, 16'h0)) begin
            n_fail++;
            $display("FAIL drain_empty: got %h expected %h", st(out_valid, full, count, overflow, out), st(0, 0, 3'd0, 1, 16'h0));
        end
    endtask

    task automatic test_clr_ovf();
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        n_tests++;
        if (overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL clr_ovf_clear: got %b expected 0", overflow);
        end
        for (int i = 0; i < 4; i++) begin
            en = 1'b1; in = 16'hA000 + 16'(i);
            tick();
        end
        // drop and clear in the same cycle: set wins
        en = 1'b1; in = 16'hDEAD; clr_ovf = 1'b1;
        tick();
        en = 1'b0; clr_ovf = 1'b0;
        n_tests++;
        if (st(out_valid, full, count, overflow, out) !== st(1, 1, 3'd4, 1, 16'hA000)) begin
            n_fail++;
            $display("FAIL clr_ovf_set_priority: got %h expected %h", st(out_valid, full, count, overflow, out), st(1, 1, 3'd4, 1, 16'hA000));
        end
    endtask

    task automatic test_full_pop_drop();
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        en = 1'b1; in = 16'hBEEF; out_ready = 1'b1;
        tick();
        en = 1'b0; out_ready = 1'b0;
        n_tests++;
        if (st(out_valid, full, count, overflow, out) !== st(1, 0, 3'd3, 1, 16'hA001)) begin
            n_fail++;
            $display("FAIL full_pop_drop: got %h expected %h", st(out_valid, full, count, overflow, out), st(1, 0, 3'd3, 1, 16'hA001));
        end
        out_ready = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            n_tests++;
            if (out !== 16'hA000 + 16'(i)) begin
                n_fail++;
                $display("FAIL full_pop_drain[%0d]: got %h expected %h", i, out, 16'hA000 + 16'(i));
            end
            tick();
        end
        out_ready = 1'b0;
        n_tests++;
        if (count !== 3'd0 || out !== 16'h0) begin
            n_fail++;
            $display("FAIL full_pop_no_beef: got count=%0d out=%h expected count=0 out=0000", count, out);
        end
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 2; i++) begin
            en = 1'b1; in = 16'h0100 + 16'(i);
            tick();
        end
        for (int k = 0; k < 10; k++) begin
            en = 1'b1; in = 16'h0102 + 16'(k); out_ready = 1'b1;
            n_tests++;
            if (count !== 3'd2 || out !== 16'h0100 + 16'(k)) begin
                n_fail++;
                $display("FAIL b2b[%0d]: got count=%0d out=%h expected count=2 out=%h", k, count, out, 16'h0100 + 16'(k));
            end
            tick();
        end
        en = 1'b0; out_ready = 1'b0;
        n_tests++;
        if (st(out_valid, full, count, overflow, out) !== st(1, 0, 3'd2, 0, 16'h010A)) begin
            n_fail++;
            $display("FAIL b2b_end: got %h expected %h", st(out_valid, full, count, overflow, out), st(1, 0, 3'd2, 0, 16'h010A));
        end
        out_ready = 1'b1;
        tick();
        n_tests++;
        if (out !== 16'h010B) begin
            n_fail++;
            $display("FAIL b2b_tail: got %h expected %h", out, 16'h010B);
        end
        tick();
        out_ready = 1'b0;
        n_tests++;
        if (count !== 3'd0) begin
            n_fail++;
            $display("FAIL b2b_empty: got count=%0d expected 0", count);
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 5; i++) begin   // fifth push is dropped
            en = 1'b1; in = 16'h0C00 + 16'(i);
            tick();
        end
        en = 1'b0; out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        n_tests++;
        if (st(out_valid, full, count, overflow, out) !== st(1, 0, 3'd3, 1, 16'h0C01)) begin
            n_fail++;
            $display("FAIL pre_reset: got %h expected %h", st(out_valid, full, count, overflow, out), st(1, 0, 3'd3, 1, 16'h0C01));
        end
        rst_b = 1'b0; en = 1'b1; in = 16'h0FFF; out_ready = 1'b1;
        #2;
        n_tests++;
        if (st(out_valid, full, count, overflow, out) !== st(1, 0, 3'd3, 1, 16'h0C01)) begin
            n_fail++;
            $display("FAIL reset_between_edges: got %h expected %h", st(out_valid, full, count, overflow, out), st(1, 0, 3'd3, 1, 16'h0C01));
        end
        tick();
        n_tests++;
        if (st(out_valid, full, count, overflow, out) !== st(0, 0, 3'd0, 0, 16'h0)) begin
            n_fail++;
            $display("FAIL reset_priority: got %h expected %h", st(out_valid, full, count, overflow, out), st(0, 0, 3'd0, 0, 16'h0));
        end
        rst_b = 1'b1; en = 1'b0; out_ready = 1'b0;
        tick();
        n_tests++;
        if (st(out_valid, full, count, overflow, out) !== st(0, 0, 3'd0, 0, 16'h0)) begin
            n_fail++;
            $display("FAIL post_reset: got %h expected %h", st(out_valid, full, count, overflow, out), st(0, 0, 3'd0, 0, 16'h0));
        end
    endtask

    initial begin
        rst_b = 1'b0; en = 1'b0; in = '0; clr_ovf = 1'b0; out_ready = 1'b0;
        #1;
        test_reset();
        test_single();
        test_fill_overflow();
        test_clr_ovf();
        test_full_pop_drop();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
